// File: rtl/io_bus_initiator_if.sv
// Command/response and I/O bus signals of the I/O bus initiator.
// The master modport is the initiator's view; the slave modport is the host/responder view.
interface io_bus_initiator_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [7:0]        txn_count;

  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_write_data;
  logic              io_write_en;
  logic [DATA_W-1:0] io_read_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, io_read_data,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, txn_count,
           io_addr, io_write_data, io_write_en
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, io_read_data,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, txn_count,
           io_addr, io_write_data, io_write_en
  );
endinterface

// File: rtl/io_bus_initiator.sv
// Bus-master bridge: runs one host read/write command at a time on the
// memory-mapped I/O bus and returns the result on the response port.
module io_bus_initiator #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int READ_WAIT = 1
) (
  input logic                clk,
  input logic                reset,
  io_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT - 1);

  state_t     state;
  logic       write_q;
  logic [3:0] wait_cnt;

  // The bus address/data registers double as the command latch, so SETUP
  // already drives the accepted address and write data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      write_q           <= 1'b0;
      wait_cnt          <= '0;
      bus.cmd_ready     <= 1'b1;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_write     <= 1'b0;
      bus.rsp_rdata     <= '0;
      bus.txn_count     <= '0;
      bus.io_addr       <= '0;
      bus.io_write_data <= '0;
      bus.io_write_en   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            write_q           <= bus.cmd_write;
            bus.io_addr       <= ADDR_W'(bus.cmd_addr);
            bus.io_write_data <= bus.cmd_write ? bus.cmd_wdata : DATA_W'(0);
            bus.cmd_ready     <= 1'b0;
            state             <= SETUP;
          end
        end
        SETUP: begin
          bus.io_write_en <= write_q;
          wait_cnt        <= WAIT_LOAD;
          state           <= ACCESS;
        end
        ACCESS: begin
          if (write_q) begin
            bus.io_write_en <= 1'b0;
            bus.rsp_write   <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (wait_cnt == 4'd0) begin
            bus.rsp_rdata <= bus.io_read_data;
            bus.rsp_write <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.txn_count <= bus.txn_count + 8'd1;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
